// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the coordinate type for the VGA timing block.
// The derived totals and sync windows are the defaults a build uses when nothing overrides them.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int PIPE_LAT_DEF  = 2;

    localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/video timing bundle between the timing generator and the sprite mappers / connector.
// frame_count is carried only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t      DrawX;
    coord_t      DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;

    modport master (output DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
`else
    modport master (output DrawX, DrawY, blank, hs, vs, frame_start);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start);
`endif

endinterface

// File: rtl/pipe_delay.sv
// DEPTH-stage shift register with an asynchronous load of rst_val; DEPTH == 0 is a plain wire.
// Used to hold blank/hs/vs back until the mapper pixel data catches up.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= rst_val;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank generation and frame_start for the 640x480 pipeline.
// Defining VGA_FRAME_COUNT_EN adds a wrapping 16-bit frame counter on the interface.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    vga_timing_gen_if.master   vif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t H_SS     = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_SE     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t V_SS     = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_SE     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: totals must fit 10 bits and PIPE_LAT must be 0..4");
    end

    coord_t     hc_q, hc_d;
    coord_t     vc_q, vc_d;
    logic       frame_start_q, frame_start_d;
    logic       blank_raw, hs_raw, vs_raw;
    logic [2:0] sync_dly;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
        // Registered pulse: fire on the edge that lands the scan on (0, V_VISIBLE).
        frame_start_d = (hc_d == '0) && (vc_d == V_VIS);
    end

    always_comb begin
        blank_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
        hs_raw    = !((hc_q >= H_SS) && (hc_q < H_SE));
        vs_raw    = !((vc_q >= V_SS) && (vc_q < V_SE));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= '0;
            vc_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_start_q <= frame_start_d;
        end
    end

    pipe_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_sync_dly (
        .clk     (vga_clk),
        .rst_n   (reset_n),
        .rst_val (3'b011),
        .din     ({blank_raw, hs_raw, vs_raw}),
        .dout    (sync_dly)
    );

    assign vif.DrawX       = hc_q;
    assign vif.DrawY       = vc_q;
    assign vif.blank       = sync_dly[2];
    assign vif.hs          = sync_dly[1];
    assign vif.vs          = sync_dly[0];
    assign vif.frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q + {15'd0, frame_start_q};
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign vif.frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (PIPE_LAT=2) and a shrunken-raster instance (PIPE_LAT=0).
// Expected delayed sync/blank values are queued as the scan advances and popped when the DUT should show them.
module tb_vga_timing_gen;

    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;   // small raster, 25 x 15
    localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sml ();

    vga_timing_gen u_def (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vif     (if_def)
    );

    vga_timing_gen #(
        .H_VISIBLE (SHV), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_VISIBLE (SVV), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
        .PIPE_LAT  (0)
    ) u_sml (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vif     (if_sml)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc, h0, v0, h1, v1;
    logic fs0, fs1;
    logic [15:0] fc0, fc1;
    logic [2:0] cur0, cur1;
    logic [2:0] q0 [$];
    int hs_lo_def = 0, bl_def = 0, hs_lo_sml = 0, bl_sml = 0, vs_lo_sml = 0, bl_vb_sml = 0;
    int maxy_sml = 0, fs_cnt = 0, last_fs = -1;

    function automatic logic [2:0] raw_t(input int h, input int v, input int hv, input int hf,
                                         input int hsy, input int vv, input int vf, input int vsy);
        logic [2:0] r;
        r[2] = (h < hv) && (v < vv);
        r[1] = !((h >= hv + hf) && (h < hv + hf + hsy));
        r[0] = !((v >= vv + vf) && (v < vv + vf + vsy));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h0 = 0; v0 = 0; h1 = 0; v1 = 0; fs0 = 1'b0; fs1 = 1'b0; fc0 = '0; fc1 = '0; cyc = 0;
        q0.delete();
        q0.push_back(3'b011);
        q0.push_back(3'b011);
        q0.push_back(raw_t(0, 0, 640, 16, 96, 480, 10, 2));
        cur0 = q0.pop_front();
        cur1 = raw_t(0, 0, SHV, SHF, SHS, SVV, SVF, SVS);
    endtask

    task automatic advance();
        fc0 = fc0 + {15'd0, fs0};
        fc1 = fc1 + {15'd0, fs1};
        h0++;
        if (h0 == 800) begin h0 = 0; v0++; if (v0 == 525) v0 = 0; end
        h1++;
        if (h1 == 25) begin h1 = 0; v1++; if (v1 == 15) v1 = 0; end
        fs0 = (h0 == 0) && (v0 == 480);
        fs1 = (h1 == 0) && (v1 == SVV);
        cyc++;
        q0.push_back(raw_t(h0, v0, 640, 16, 96, 480, 10, 2));
        cur0 = q0.pop_front();
        cur1 = raw_t(h1, v1, SHV, SHF, SHS, SVV, SVF, SVS);
    endtask

    task automatic check_now();
        chk("def_drawx", if_def.DrawX, h0);
        chk("def_drawy", if_def.DrawY, v0);
        chk("def_blank", if_def.blank, cur0[2]);
        chk("def_hs",    if_def.hs,    cur0[1]);
        chk("def_vs",    if_def.vs,    cur0[0]);
        chk("def_fs",    if_def.frame_start, fs0);
        chk("sml_drawx", if_sml.DrawX, h1);
        chk("sml_drawy", if_sml.DrawY, v1);
        chk("sml_blank", if_sml.blank, cur1[2]);
        chk("sml_hs",    if_sml.hs,    cur1[1]);
        chk("sml_vs",    if_sml.vs,    cur1[0]);
        chk("sml_fs",    if_sml.frame_start, fs1);
`ifdef VGA_FRAME_COUNT_EN
        chk("def_fcount", if_def.frame_count, fc0);
        chk("sml_fcount", if_sml.frame_count, fc1);
`endif
        if (cyc < 802) begin
            if (!if_def.hs)   hs_lo_def++;
            if (if_def.blank) bl_def++;
        end
        if (cyc < 375) begin
            if (v1 == 0 && !if_sml.hs)   hs_lo_sml++;
            if (v1 == 0 && if_sml.blank) bl_sml++;
            if (!if_sml.vs)              vs_lo_sml++;
        end
        if (v1 >= SVV && if_sml.blank) bl_vb_sml++;
        if (int'(if_sml.DrawY) > maxy_sml) maxy_sml = int'(if_sml.DrawY);
        if (if_sml.frame_start) begin
            fs_cnt++;
            chk("fs_pos_x", if_sml.DrawX, 0);
            chk("fs_pos_y", if_sml.DrawY, SVV);
            if (last_fs >= 0) chk("fs_spacing", cyc - last_fs, 375);
            last_fs = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
            advance();
            check_now();
        end
    endtask

    initial begin
        int guard;
        reset_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_def_drawx", if_def.DrawX, 0);
        chk("rst_def_drawy", if_def.DrawY, 0);
        chk("rst_def_blank", if_def.blank, 0);
        chk("rst_def_hs",    if_def.hs, 1);
        chk("rst_def_vs",    if_def.vs, 1);
        chk("rst_def_fs",    if_def.frame_start, 0);
        chk("rst_sml_drawx", if_sml.DrawX, 0);
        chk("rst_sml_fs",    if_sml.frame_start, 0);

        #2 reset_n = 1'b1;
        model_reset();
        check_now();
        run(1200);

        chk("def_hs_low_cycles",    hs_lo_def, 96);
        chk("def_blank_hi_cycles",  bl_def, 640);
        chk("sml_hs_low_cycles",    hs_lo_sml, SHS);
        chk("sml_blank_hi_cycles",  bl_sml, SHV);
        chk("sml_vs_low_cycles",    vs_lo_sml, SVS * 25);
        chk("sml_blank_in_vblank",  bl_vb_sml, 0);
        chk("sml_max_drawy",        maxy_sml, 14);
        chk("sml_frame_pulses",     fs_cnt, 3);

        // Park the small raster mid-frame, inside the visible area, then pull reset between edges.
        guard = 0;
        while (!(h1 == 10 && v1 == 5) && guard < 400) begin
            run(1);
            guard++;
        end
        chk("mid_frame_reached", {31'd0, (h1 == 10 && v1 == 5)}, 1);
        chk("mid_def_blank_pre", if_def.blank, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_def_drawx", if_def.DrawX, 0);
        chk("async_def_drawy", if_def.DrawY, 0);
        chk("async_def_blank", if_def.blank, 0);
        chk("async_def_hs",    if_def.hs, 1);
        chk("async_sml_drawx", if_sml.DrawX, 0);
        chk("async_sml_drawy", if_sml.DrawY, 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("async_sml_fcount", if_sml.frame_count, 0);
`endif
        repeat (2) @(posedge vga_clk);
        #1;
        chk("held_def_drawx", if_def.DrawX, 0);
        chk("held_sml_drawx", if_sml.DrawX, 0);

        #2 reset_n = 1'b1;
        model_reset();
        last_fs = -1;
        check_now();
        run(900);

`ifdef VGA_FRAME_COUNT_EN
        chk("fcount_after_two", if_sml.frame_count, 2);
        force u_sml.frame_count_q = 16'hFFFF;
        fc1 = 16'hFFFF;
        #3 release u_sml.frame_count_q;
        @(posedge vga_clk);
        #1;
        advance();
        check_now();
        run(400);
        chk("fcount_wrap", if_sml.frame_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
